// File: rtl/hyperram_xfer_stm.sv
// HyperRAM transaction sequencer: command-address, initial latency,
// and 1..MAX_BURST word data phase for register and memory space.
module hyperram_xfer_stm #(
    parameter  int MAX_BURST  = 16,
    parameter  int LAT_CYCLES = 6,
    parameter  int FIXED_LAT  = 0,
    parameter  int T_RWR      = 2,
    parameter  int RD_TIMEOUT = 64,
    localparam int LW         = $clog2(MAX_BURST + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_rw,
    input  logic          i_cmd_as,
    input  logic [31:0]   i_cmd_addr,
    input  logic [LW-1:0] i_cmd_len,
    input  logic [15:0]   i_wr_data,
    input  logic [1:0]    i_wr_mask,
    output logic          o_wr_ready,
    output logic [15:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic          o_done,
    output logic          o_err,
    output logic          o_busy,
    output logic          o_csn,
    output logic          o_oe,
    output logic          o_oe_clk,
    output logic [15:0]   o_dq_out,
    input  logic [15:0]   i_dq_in,
    input  logic          i_rwds_in,
    output logic          o_rwds_out,
    output logic          o_rwds_oe
);

    localparam int C1 = (2 * LAT_CYCLES > RD_TIMEOUT) ? 2 * LAT_CYCLES : RD_TIMEOUT;
    localparam int C2 = (C1 > T_RWR) ? C1 : T_RWR;
    localparam int CW = $clog2(C2 + 4);

    typedef enum logic [2:0] {
        S_IDLE, S_CA, S_LAT, S_DATA, S_DONE, S_RECOV
    } state_t;

    state_t        r_state;
    state_t        w_nxt;
    logic [CW-1:0] r_cyc;
    logic [LW-1:0] r_words;
    logic [LW-1:0] r_len;
    logic [47:0]   r_ca;
    logic          r_rw;
    logic          r_as;
    logic          r_err;
    logic          r_rej;
    logic          r_lat_dbl;
    logic          r_live;
    logic [15:0]   r_rd_data;
    logic          r_rd_valid;

    logic          w_acc;
    logic          w_bad;
    logic          w_cap;
    logic          w_to;
    logic          w_last;
    logic [CW-1:0] w_lat_len;

    assign w_bad     = (i_cmd_len == '0) || (i_cmd_len > LW'(MAX_BURST));
    assign w_last    = (r_words == r_len - LW'(1));
    assign w_lat_len = ((FIXED_LAT != 0) || r_lat_dbl) ? CW'(2 * LAT_CYCLES)
                                                       : CW'(LAT_CYCLES);
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

    // Next-state and bus/handshake outputs decoded from the current state
    always_comb begin
        w_nxt       = r_state;
        w_acc       = 1'b0;
        w_cap       = 1'b0;
        w_to        = 1'b0;
        o_cmd_ready = 1'b0;
        o_busy      = 1'b1;
        o_csn       = 1'b1;
        o_oe        = 1'b0;
        o_oe_clk    = 1'b0;
        o_dq_out    = 16'h0000;
        o_wr_ready  = 1'b0;
        o_rwds_out  = 1'b0;
        o_rwds_oe   = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy      = 1'b0;
                o_cmd_ready = r_live;
                if (i_cmd_valid && r_live) begin
                    w_acc = 1'b1;
                    w_nxt = w_bad ? S_DONE : S_CA;
                end
            end
            S_CA: begin
                o_csn    = 1'b0;
                o_oe     = 1'b1;
                o_oe_clk = 1'b1;
                case (r_cyc[1:0])
                    2'd0:    o_dq_out = r_ca[47:32];
                    2'd1:    o_dq_out = r_ca[31:16];
                    default: o_dq_out = r_ca[15:0];
                endcase
                if (r_cyc == CW'(2))
                    w_nxt = (r_as && !r_rw) ? S_DATA : S_LAT;
            end
            S_LAT: begin
                o_csn    = 1'b0;
                o_oe_clk = 1'b1;
                if (r_cyc == w_lat_len - CW'(1))
                    w_nxt = S_DATA;
            end
            S_DATA: begin
                o_csn    = 1'b0;
                o_oe_clk = 1'b1;
                if (!r_rw) begin
                    o_oe       = 1'b1;
                    o_dq_out   = i_wr_data;
                    o_wr_ready = 1'b1;
                    o_rwds_oe  = !r_as;
                    o_rwds_out = !r_as && (|i_wr_mask);
                    if (w_last)
                        w_nxt = S_DONE;
                end else begin
                    w_cap = i_rwds_in;
                    if (w_cap && w_last) begin
                        w_nxt = S_DONE;
                    end else if (!w_cap && r_cyc == CW'(RD_TIMEOUT - 1)) begin
                        w_to  = 1'b1;
                        w_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                o_err  = r_err;
                w_nxt  = r_rej ? S_IDLE : S_RECOV;
            end
            S_RECOV: begin
                if (r_cyc == CW'(T_RWR - 1))
                    w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_nxt;
    end

    // Command latch, phase counters, latency flag and read capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_live     <= 1'b0;
            r_cyc      <= '0;
            r_words    <= '0;
            r_len      <= '0;
            r_ca       <= '0;
            r_rw       <= 1'b0;
            r_as       <= 1'b0;
            r_err      <= 1'b0;
            r_rej      <= 1'b0;
            r_lat_dbl  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_rd_valid <= w_cap;
            if (w_cap)
                r_rd_data <= i_dq_in;
            if (w_nxt != r_state || w_cap)
                r_cyc <= '0;
            else if (r_state != S_IDLE)
                r_cyc <= r_cyc + CW'(1);
            if (r_state != S_DATA)
                r_words <= '0;
            else if (!r_rw || w_cap)
                r_words <= r_words + LW'(1);
            if (r_state == S_CA && r_cyc == '0)
                r_lat_dbl <= i_rwds_in;
            if (w_acc) begin
                r_rw  <= i_cmd_rw;
                r_as  <= i_cmd_as;
                r_len <= i_cmd_len;
                r_err <= w_bad;
                r_rej <= w_bad;
                r_ca  <= {i_cmd_rw, i_cmd_as, 1'b1, i_cmd_addr[31:3],
                          13'd0, i_cmd_addr[2:0]};
            end else if (w_to) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hyperram_xfer_stm.sv
// Testbench for hyperram_xfer_stm: per-transaction cycle schedule
// derived from the protocol rules, driven with random data and RWDS.
module tb_hyperram_xfer_stm;

    localparam int MB = 16;
    localparam int LC = 6;
    localparam int TR = 2;
    localparam int TO = 64;
    localparam int LW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          i_rst_n;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic          i_cmd_rw;
    logic          i_cmd_as;
    logic [31:0]   i_cmd_addr;
    logic [LW-1:0] i_cmd_len;
    logic [15:0]   i_wr_data;
    logic [1:0]    i_wr_mask;
    logic          o_wr_ready;
    logic [15:0]   o_rd_data;
    logic          o_rd_valid;
    logic          o_done;
    logic          o_err;
    logic          o_busy;
    logic          o_csn;
    logic          o_oe;
    logic          o_oe_clk;
    logic [15:0]   o_dq_out;
    logic [15:0]   i_dq_in;
    logic          i_rwds_in;
    logic          o_rwds_out;
    logic          o_rwds_oe;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hyperram_xfer_stm #(
        .MAX_BURST (MB),
        .LAT_CYCLES(LC),
        .FIXED_LAT (0),
        .T_RWR     (TR),
        .RD_TIMEOUT(TO)
    ) u_dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_rw   (i_cmd_rw),
        .i_cmd_as   (i_cmd_as),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_len  (i_cmd_len),
        .i_wr_data  (i_wr_data),
        .i_wr_mask  (i_wr_mask),
        .o_wr_ready (o_wr_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_busy     (o_busy),
        .o_csn      (o_csn),
        .o_oe       (o_oe),
        .o_oe_clk   (o_oe_clk),
        .o_dq_out   (o_dq_out),
        .i_dq_in    (i_dq_in),
        .i_rwds_in  (i_rwds_in),
        .o_rwds_out (o_rwds_out),
        .o_rwds_oe  (o_rwds_oe)
    );

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_cmd_valid = 1'b0;
            i_rwds_in   = 1'($urandom);
            i_dq_in     = 16'($urandom);
            #4;
            chk("idle_ready", o_cmd_ready, 1'b1);
            chk("idle_busy", o_busy, 1'b0);
            chk("idle_csn", o_csn, 1'b1);
            tick();
        end
    endtask

    // mode: 0 dense rwds, 1 stuck low, 2 sparse, 3 high from DATA start
    task automatic run_txn(input bit rw, input bit as,
                           input logic [31:0] addr, input int len,
                           input int mode, input bit dbl);
        bit          pat [0:2047];
        bit          cap [0:2047];
        bit          bad;
        bit          e;
        bit          wd;
        bit          rv;
        int          lat;
        int          d;
        int          done_r;
        int          ready_r;
        int          caps;
        int          gap;
        logic [47:0] ca;
        logic [15:0] prev_dq;

        bad = (len < 1) || (len > MB);
        lat = (as && !rw) ? 0 : (dbl ? 2 * LC : LC);
        d   = 4 + lat;
        for (int r = 0; r < 2048; r++) begin
            pat[r] = 1'($urandom);
            cap[r] = 1'b0;
        end
        pat[1] = dbl;
        if (rw && !bad) begin
            for (int r = d; r < 2048; r++) begin
                case (mode)
                    1:       pat[r] = 1'b0;
                    2:       pat[r] = ($urandom_range(0, 39) == 0);
                    3:       pat[r] = 1'b1;
                    default: pat[r] = ($urandom_range(0, 9) < 7);
                endcase
            end
            if (mode == 3)
                for (int r = 2; r < d; r++) pat[r] = 1'b0;
        end
        e      = 1'b0;
        done_r = 0;
        if (bad) begin
            done_r = 1;
            e      = 1'b1;
        end else if (!rw) begin
            done_r = d + len;
        end else begin
            caps = 0;
            gap  = 0;
            for (int r = d; r < 2000; r++) begin
                if (pat[r]) begin
                    cap[r] = 1'b1;
                    caps++;
                    gap = 0;
                    if (caps == len) begin
                        done_r = r + 1;
                        break;
                    end
                end else begin
                    gap++;
                    if (gap == TO) begin
                        done_r = r + 1;
                        e      = 1'b1;
                        break;
                    end
                end
            end
        end
        ready_r = bad ? 2 : done_r + 1 + TR;
        ca      = {rw, as, 1'b1, addr[31:3], 13'd0, addr[2:0]};
        prev_dq = '0;

        for (int r = 0; r < ready_r; r++) begin
            i_cmd_valid = (r == 0);
            if (r == 0) begin
                i_cmd_rw   = rw;
                i_cmd_as   = as;
                i_cmd_addr = addr;
                i_cmd_len  = LW'(len);
            end else begin
                i_cmd_rw   = 1'($urandom);
                i_cmd_as   = 1'($urandom);
                i_cmd_addr = $urandom;
                i_cmd_len  = LW'($urandom);
            end
            i_rwds_in = pat[r];
            i_dq_in   = 16'($urandom);
            i_wr_data = 16'($urandom);
            i_wr_mask = 2'($urandom);
            wd = !rw && !bad && r >= d && r < d + len;
            rv = rw && !bad && r > 0 && cap[r-1];
            #4;
            chk("ready", o_cmd_ready, r == 0);
            chk("busy", o_busy, r >= 1);
            chk("csn", o_csn, !(!bad && r >= 1 && r < done_r));
            chk("oe_clk", o_oe_clk, !bad && r >= 1 && r < done_r);
            chk("done", o_done, r == done_r);
            chk("err", o_err, (r == done_r) && e);
            chk("oe", o_oe, (!bad && r >= 1 && r <= 3) || wd);
            chk("wr_ready", o_wr_ready, wd);
            chk("rwds_oe", o_rwds_oe, wd && !as);
            chk("rd_valid", o_rd_valid, rv);
            if (!bad && r >= 1 && r <= 3)
                chk("ca_word", o_dq_out, ca[16*(3-r) +: 16]);
            if (wd) begin
                chk("wr_dq", o_dq_out, i_wr_data);
                if (!as)
                    chk("rwds_out", o_rwds_out, |i_wr_mask);
            end
            if (rv)
                chk("rd_data", o_rd_data, prev_dq);
            prev_dq = i_dq_in;
            tick();
        end
    endtask

    initial begin
        bit   rw;
        bit   as;
        int   len;
        int   mode;

        i_rst_n     = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_rw    = 1'b0;
        i_cmd_as    = 1'b0;
        i_cmd_addr  = '0;
        i_cmd_len   = '0;
        i_wr_data   = '0;
        i_wr_mask   = '0;
        i_dq_in     = '0;
        i_rwds_in   = 1'b0;
        #12;
        chk("rst_csn", o_csn, 1'b1);
        chk("rst_ready", o_cmd_ready, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_oe", o_oe, 1'b0);
        chk("rst_oe_clk", o_oe_clk, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_rd_valid", o_rd_valid, 1'b0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        #3;
        chk("rel_ready", o_cmd_ready, 1'b0);
        tick();

        run_txn(1'b1, 1'b0, 32'h0000_0100, 4, 3, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0100, 4, 3, 1'b1);
        run_txn(1'b0, 1'b1, 32'h0100_0000, 1, 0, 1'b0);
        run_txn(1'b0, 1'b0, $urandom, 16, 0, 1'b0);
        run_txn(1'b1, 1'b0, $urandom, 0, 0, 1'b0);
        run_txn(1'b0, 1'b0, $urandom, 17, 0, 1'b0);
        run_txn(1'b1, 1'b0, $urandom, 4, 1, 1'b0);
        idle(2);

        for (int k = 0; k < 30; k++) begin
            rw = 1'($urandom);
            as = 1'($urandom);
            if ($urandom_range(0, 9) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MB + 1, 31));
            else
                len = int'($urandom_range(1, MB));
            if ($urandom_range(0, 9) == 0)
                mode = 1;
            else if ($urandom_range(0, 4) == 0)
                mode = 2;
            else
                mode = 0;
            run_txn(rw, as, $urandom, len, mode, 1'($urandom));
            if ($urandom_range(0, 2) == 0)
                idle(int'($urandom_range(1, 3)));
        end

        i_cmd_valid = 1'b1;
        i_cmd_rw    = 1'b1;
        i_cmd_as    = 1'b0;
        i_cmd_addr  = 32'h0000_0040;
        i_cmd_len   = LW'(4);
        i_rwds_in   = 1'b0;
        tick();
        i_cmd_valid = 1'b0;
        repeat (11) tick();
        #2;
        chk("pre_rst_csn", o_csn, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("arst_csn", o_csn, 1'b1);
        chk("arst_oe", o_oe, 1'b0);
        chk("arst_oe_clk", o_oe_clk, 1'b0);
        chk("arst_busy", o_busy, 1'b0);
        chk("arst_ready", o_cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        tick();
        #3;
        chk("post_rst_ready", o_cmd_ready, 1'b1);
        chk("post_rst_csn", o_csn, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
